// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer
//   Read-side engine for sync_fifo. Pops bytes through the FIFO read port and
//   packs PACK of them into one wide word on a valid/ready stream. Lane 0
//   (LSBs) holds the first byte popped.
//
// Ports
//   clk           in   single clock, rising edge
//   reset         in   synchronous, active-high (shared with sync_fifo)
//   fifo_empty    in   sync_fifo empty
//   fifo_r_enable out  sync_fifo r_enable (pop)
//   fifo_r_data   in   sync_fifo r_data, valid the cycle after a pop
//   m_valid       out  output word valid
//   m_ready       in   downstream accept
//   m_data        out  packed word
//   m_keep        out  per-lane valid mask
//
// Build option
//   FIFO_RD_PACKER_FLUSH_EN : when defined, a partial word is flushed after
//   TIMEOUT idle cycles with m_keep marking the filled lanes. When undefined,
//   partial words wait for more data and m_keep is all ones on every word.
//
// Output register states
//   state    | meaning
//   ST_EMPTY | no word presented, m_valid=0
//   ST_FULL  | word presented, m_data/m_keep held until m_valid && m_ready

module fifo_rd_packer #(
  parameter int DATA_W  = 8,
  parameter int PACK    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fifo_empty,
  output logic                     fifo_r_enable,
  input  logic [DATA_W-1:0]        fifo_r_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [DATA_W*PACK-1:0]   m_data,
  output logic [PACK-1:0]          m_keep
);

  localparam int WW = DATA_W * PACK;
  localparam int CW = $clog2(PACK + 1);

  localparam logic [CW-1:0] C_FULL   = CW'(PACK);
  localparam logic [CW-1:0] C_LAST   = CW'(PACK - 1);
  localparam logic [CW:0]   LVL_FULL = (CW + 1)'(PACK);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]      out_st_q, out_st_d;
  logic [WW-1:0]   data_q, data_d;
  logic [PACK-1:0] keep_q, keep_d;
  logic [WW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   c_q, c_d;
  logic            p_q, p_d;

  logic            out_free;
  logic [CW:0]     lvl;
  logic [WW-1:0]   acc_w;
  logic [CW-1:0]   c_w;
  logic            load;
  logic [WW-1:0]   load_word;
  logic [PACK-1:0] load_keep;
  logic [PACK-1:0] keep_part;
  logic            flush_fire;

  // The output register can take a word this cycle if it is empty or its
  // current word is being accepted.
  assign out_free = (out_st_q == ST_EMPTY) || m_ready;

  // Bytes committed to the packer: captured lanes plus the one in flight.
  assign lvl = {1'b0, c_q} + (CW + 1)'(p_q);

  // Pop while there is room for the byte. When lvl == PACK the only way to
  // make room is a load this cycle, which happens exactly when the output
  // frees; allowing the pop then keeps pops back-to-back across word
  // boundaries instead of leaving a one-cycle bubble per word.
  assign fifo_r_enable = !reset && !fifo_empty &&
                         ((lvl < LVL_FULL) || ((lvl == LVL_FULL) && out_free));

  assign p_d = fifo_r_enable;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_q, idle_d;
  logic          idle_cond;
  logic          idle_tc;

  // Idle means a partial word is parked with nothing in flight and nothing
  // to pop; any pop or capture breaks the condition and reloads the timer.
  assign idle_cond = (c_q != '0) && (c_q < C_FULL) && !p_q && fifo_empty;
  assign idle_tc   = idle_cond && (idle_q == TW'(1));
  assign flush_fire = idle_tc && out_free;

  always_comb begin
    idle_d = idle_q;
    if (!idle_cond) begin
      idle_d = TW'(TIMEOUT);
    end else if (idle_tc) begin
      // Hold at terminal count until the output can take the partial word.
      idle_d = flush_fire ? TW'(TIMEOUT) : idle_q;
    end else begin
      idle_d = idle_q - TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q <= TW'(TIMEOUT);
    end else begin
      idle_q <= idle_d;
    end
  end
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = TIMEOUT;
  assign flush_fire     = 1'b0;
`endif

  always_comb begin
    keep_part = '0;
    for (int i = 0; i < PACK; i++) begin
      keep_part[i] = (i < int'(c_q));
    end
  end

  // Accumulator view after this cycle's capture (if any).
  always_comb begin
    acc_w = acc_q;
    c_w   = c_q;
    if (p_q && (c_q < C_FULL)) begin
      acc_w[int'(c_q)*DATA_W +: DATA_W] = fifo_r_data;
      c_w = c_q + CW'(1);
    end
  end

  always_comb begin
    acc_d     = acc_q;
    c_d       = c_q;
    load      = 1'b0;
    load_word = '0;
    load_keep = '0;
    if (c_q == C_FULL) begin
      // Complete word parked behind a full output register.
      if (out_free) begin
        load      = 1'b1;
        load_word = acc_q;
        load_keep = '1;
        acc_d     = '0;
        c_d       = '0;
        if (p_q) begin
          acc_d[DATA_W-1:0] = fifo_r_data;
          c_d = CW'(1);
        end
      end
    end else if (p_q) begin
      if ((c_q == C_LAST) && out_free) begin
        load      = 1'b1;
        load_word = acc_w;
        load_keep = '1;
        acc_d     = '0;
        c_d       = '0;
      end else begin
        acc_d = acc_w;
        c_d   = c_w;
      end
    end else if (flush_fire) begin
      // Unused lanes of a partial word are already zero: the accumulator is
      // cleared on every load.
      load      = 1'b1;
      load_word = acc_q;
      load_keep = keep_part;
      acc_d     = '0;
      c_d       = '0;
    end
  end

  always_comb begin
    out_st_d = out_st_q;
    data_d   = data_q;
    keep_d   = keep_q;
    case (out_st_q)
      ST_EMPTY: begin
        if (load) begin
          out_st_d = ST_FULL;
          data_d   = load_word;
          keep_d   = load_keep;
        end
      end
      ST_FULL: begin
        if (m_ready) begin
          if (load) begin
            data_d = load_word;
            keep_d = load_keep;
          end else begin
            out_st_d = ST_EMPTY;
          end
        end
      end
      default: out_st_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_st_q <= ST_EMPTY;
      data_q   <= '0;
      keep_q   <= '0;
      acc_q    <= '0;
      c_q      <= '0;
      p_q      <= 1'b0;
    end else begin
      out_st_q <= out_st_d;
      data_q   <= data_d;
      keep_q   <= keep_d;
      acc_q    <= acc_d;
      c_q      <= c_d;
      p_q      <= p_d;
    end
  end

  assign m_valid = (out_st_q == ST_FULL);
  assign m_data  = data_q;
  assign m_keep  = keep_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
module tb_fifo_rd_packer;

  localparam int DW = 8;
  localparam int PK = 4;
  localparam int WW = DW * PK;

  logic          clk = 1'b0;
  logic          reset;
  logic          fifo_empty;
  logic          fifo_r_enable;
  logic [DW-1:0] fifo_r_data;
  logic          m_valid;
  logic          m_ready;
  logic [WW-1:0] m_data;
  logic [PK-1:0] m_keep;

  fifo_rd_packer #(.DATA_W(DW), .PACK(PK), .TIMEOUT(16)) dut (
    .clk           (clk),
    .reset         (reset),
    .fifo_empty    (fifo_empty),
    .fifo_r_enable (fifo_r_enable),
    .fifo_r_data   (fifo_r_data),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_keep        (m_keep)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] fifo_q[$];   // contents of the emulated sync_fifo
  logic [DW-1:0] exp_q[$];    // bytes popped but not yet delivered
  logic [WW-1:0] got_w[$];
  logic [PK-1:0] got_k[$];
  int            hs_cyc[$];

  int  cyc = 0;
  bit  pop_now = 1'b0;
  bit  prev_reset = 1'b0;
  bit  hold_prev = 1'b0;
  logic [WW-1:0] hold_data;
  logic [PK-1:0] hold_keep;
  int  first_pop_cyc = -1;
  int  first_valid_cyc = -1;
  int  popped_total = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Per-cycle comparison against the byte-stream model.
  always @(negedge clk) begin
    int            n;
    logic [WW-1:0] ew;
    logic [PK-1:0] ek;
    cyc++;
    if (reset) chk("rst_ren", fifo_r_enable, 0);
    if (prev_reset) begin
      chk("rst_valid", m_valid, 0);
      chk("rst_keep", m_keep, 0);
      chk("rst_data", m_data, 0);
    end
    if (fifo_empty) chk("pop_on_empty", fifo_r_enable, 0);
    pop_now = fifo_r_enable;
    if (fifo_r_enable && first_pop_cyc < 0) first_pop_cyc = cyc;
    if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (hold_prev) begin
      chk("hold_valid", m_valid, 1);
      chk("hold_data", m_data, hold_data);
      chk("hold_keep", m_keep, hold_keep);
    end
    if (m_valid && m_ready && !reset) begin
      n = (exp_q.size() >= PK) ? PK : exp_q.size();
      ew = '0;
      for (int i = 0; i < n; i++) ew[i*DW +: DW] = exp_q[i];
      ek = '1;
`ifdef FIFO_RD_PACKER_FLUSH_EN
      if (n < PK) ek = PK'((1 << n) - 1);
`else
      if (n < PK) chk("underflow", n, PK);
`endif
      chk("word_data", m_data, ew);
      chk("word_keep", m_keep, ek);
      for (int i = 0; i < n; i++) void'(exp_q.pop_front());
      got_w.push_back(m_data);
      got_k.push_back(m_keep);
      hs_cyc.push_back(cyc);
    end
    if (exp_q.size() > 2 * PK) chk("buffer_bound", exp_q.size(), 2 * PK);
    hold_prev  = m_valid && !m_ready && !reset;
    hold_data  = m_data;
    hold_keep  = m_keep;
    prev_reset = reset;
  end

  // One clock: emulates sync_fifo read timing (r_data valid after the pop).
  task automatic step();
    logic [DW-1:0] b;
    @(posedge clk);
    #1;
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
    end else if (pop_now) begin
      if (fifo_q.size() == 0) begin
        chk("fifo_underrun", 1, 0);
      end else begin
        b = fifo_q.pop_front();
        fifo_r_data = b;
        exp_q.push_back(b);
        popped_total++;
      end
    end
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic cycles(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic push_byte(logic [DW-1:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  task automatic wait_words(int n, int budget);
    int k = 0;
    while (got_w.size() < n && k < budget) begin
      step();
      k++;
    end
    checks++;
    if (got_w.size() < n) begin
      errors++;
      $display("FAIL wait_words actual=%0d required=%0d", got_w.size(), n);
    end
  endtask

  task automatic clear_log();
    got_w.delete();
    got_k.delete();
    hs_cyc.delete();
  endtask

  initial begin
    reset       = 1'b1;
    m_ready     = 1'b0;
    fifo_empty  = 1'b1;
    fifo_r_data = '0;
    cycles(2);
    chk("init_valid", m_valid, 0);
    chk("init_keep", m_keep, 0);
    reset = 1'b0;
    step();

    // Streaming
    clear_log();
    first_pop_cyc   = -1;
    first_valid_cyc = -1;
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push_byte(DW'(i));
    wait_words(2, 40);
    if (got_w.size() >= 2) begin
      chk("stream_w0", got_w[0], 32'h04030201);
      chk("stream_w1", got_w[1], 32'h08070605);
      chk("stream_gap", hs_cyc[1] - hs_cyc[0], PK);
    end
    chk("stream_latency", first_valid_cyc - first_pop_cyc, 5);
    cycles(3);

    // Backpressure
    clear_log();
    m_ready = 1'b0;
    popped_total = 0;
    for (int i = 1; i <= 12; i++) push_byte(DW'(i));
    cycles(20);
    chk("bp_popped", popped_total, 8);
    chk("bp_fifo_left", fifo_q.size(), 4);
    chk("bp_valid", m_valid, 1);
    chk("bp_data", m_data, 32'h04030201);
    m_ready = 1'b1;
    wait_words(3, 40);
    if (got_w.size() >= 3) begin
      chk("bp_w0", got_w[0], 32'h04030201);
      chk("bp_w1", got_w[1], 32'h08070605);
      chk("bp_w2", got_w[2], 32'h0C0B0A09);
    end
    cycles(3);
    chk("bp_drained", exp_q.size(), 0);

    // m_ready toggling every cycle under continuous input
    clear_log();
    for (int i = 8'h10; i <= 8'h27; i++) push_byte(DW'(i));
    for (int k = 0; k < 200 && got_w.size() < 6; k++) begin
      m_ready = ~m_ready;
      step();
    end
    chk("tog_words", got_w.size(), 6);
    if (got_w.size() >= 6) begin
      chk("tog_w0", got_w[0], 32'h13121110);
      chk("tog_w5", got_w[5], 32'h27262524);
    end
    m_ready = 1'b1;
    cycles(3);
    chk("tog_drained", exp_q.size(), 0);

    // Reset mid-word
    clear_log();
    push_byte(8'h55);
    push_byte(8'h66);
    cycles(4);
    chk("pre_rst_valid", m_valid, 0);
    reset = 1'b1;
    push_byte(8'h77);
    #2;
    chk("rst_mid_ren", fifo_r_enable, 0);
    step();
    chk("rst_mid_valid", m_valid, 0);
    chk("rst_mid_keep", m_keep, 0);
    reset = 1'b0;
    step();
    for (int i = 8'hA1; i <= 8'hA4; i++) push_byte(DW'(i));
    wait_words(1, 40);
    if (got_w.size() >= 1) chk("rst_next_word", got_w[0], 32'hA4A3A2A1);
    cycles(3);

    // Partial word: flush or wait
    clear_log();
    push_byte(8'hAA);
    push_byte(8'hBB);
`ifdef FIFO_RD_PACKER_FLUSH_EN
    wait_words(1, 40);
    if (got_w.size() >= 1) begin
      chk("flush_data", got_w[0], 32'h0000BBAA);
      chk("flush_keep", got_k[0], 4'b0011);
    end
`else
    cycles(100);
    chk("noflush_words", got_w.size(), 0);
    chk("noflush_valid", m_valid, 0);
    push_byte(8'hCC);
    push_byte(8'hDD);
    wait_words(1, 40);
    if (got_w.size() >= 1) begin
      chk("noflush_data", got_w[0], 32'hDDCCBBAA);
      chk("noflush_keep", got_k[0], 4'b1111);
    end
`endif
    cycles(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
